cas_player: RTL and testbench
=============================

# cas_player

Cassette playback engine for the HT1080Z core. It captures a `.CAS` image from the HPS download stream into a private 64 KB buffer. It then replays the image as a TRS-80 Level II 500-baud pulse stream on the cassette-input line, gated by the cassette motor relay. It sits between the hps_io download port (index 1, cassette region) and the core's cassette input port.

## Interface

Parameters:
- `BIT_1X`, 84000: clk_sys cycles per bit cell at 1x (42 MHz / 500 Bd).
- `PW_1X`, 5250: pulse width in cycles at 1x (125 µs).

Ports:
- `clk_sys`, in, 1: single clock, 42 MHz.
- `reset`, in, 1: synchronous, active-high.
- `ld_go`, in, 1: cassette download in progress.
- `ld_wr`, in, 1: download byte strobe, one cycle.
- `ld_addr`, in, 16: download byte address.
- `ld_data`, in, 8: download byte.
- `motor`, in, 1: cassette motor relay from the core; playback advances only while high.
- `rewind`, in, 1: one-cycle pulse that returns playback to byte 0.
- `overclock`, in, 2: CPU speed select (0 = 1x, 1 = 1.5x, 2 = 2x, 3 = 12x). It scales the tape timing.
- `cas_out`, out, 1: cassette level into the core.
- `playing`, out, 1: high while pulses are being generated.
- `tape_end`, out, 1: high once all bytes have been sent.
- `tape_pos`, out, 16: index of the byte currently being sent.

## Operation

- **Buffer:** 64K×8 dual-use block RAM.
  - A write occurs when `ld_go & ld_wr`, at `ld_addr`.
  - The RAM read port is registered, with 1-cycle latency.
- **Length register `len`** (17 bits):
  - Cleared to 0 on the rising edge of `ld_go`.
  - On each write, `len <= max(len, ld_addr+1)`.
  - `len` and RAM contents are not affected by `reset`.
- **Timing table**, selected by `overclock`, latched at each bit-cell start:

  | `overclock` | Bit cell T (cycles) | Pulse PW (cycles) |
  |---|---|---|
  | 0 | 84000 | 5250 |
  | 1 | 56000 | 3500 |
  | 2 | 42000 | 2625 |
  | 3 | 7000 | 437 |

- **Bit cell encoding:**
  - Every cell starts with a clock pulse: `cas_out` = 1 for phase [0, PW).
  - If the bit is 1, a data pulse follows: `cas_out` = 1 for phase [T/2, T/2+PW).
  - Otherwise `cas_out` = 0.
  - Bits are sent MSB first.
- **States:**
  - IDLE: entered after reset, rewind or download.
    - `pos` = 0, `cas_out` = 0.
    - Moves to FETCH when `motor` = 1, `ld_go` = 0 and `len` > 0.
  - FETCH: issue a read of `pos`, wait 1 cycle, load the shift register, go to CELL.
  - CELL: the phase counter runs 0..T-1.
    - At phase T-1 the shift register shifts.
    - After bit 7 completes, `pos` increments.
    - If `pos+1 == len`, go to END; otherwise continue in CELL with the prefetched byte.
  - END: `cas_out` = 0, `tape_end` = 1. It holds there until rewind, reset or a new download.
- **Prefetch:** at the start of bit 7, read `pos+1` into a holding register. Byte boundaries after the first are therefore gapless.
- **Motor low in CELL:** the phase counter and shift register freeze and `cas_out` is forced to 0. When `motor` returns, the cell resumes at the frozen phase.
- **`ld_go` high in any state:** forces IDLE immediately, with `cas_out` = 0 and `tape_end` = 0.
- **`rewind`:** enters IDLE and clears `tape_end`; RAM and `len` are kept.
- **Simultaneous events:** `reset` beats `ld_go`, which beats `rewind`, which beats `motor`.
- **Output derivation:** `playing` = (state == CELL) & `motor`. `tape_pos` = `pos`.

## Timing

- **Reset values:** `cas_out` 0, `playing` 0, `tape_end` 0, `tape_pos` 0, state IDLE. Reset mid-playback takes effect on the next edge; no partial pulse completes.
- **Start latency:** `motor` rises in IDLE at cycle 0.
  - FETCH during cycles 1–2.
  - First clock pulse: `cas_out` = 1 at cycle 3.
- `cas_out` is registered, and pulse edges land exactly at phase 0, PW, T/2 and T/2+PW.
- An `overclock` change mid-cell does not alter the current cell.
- **Arithmetic widths:** phase counter 17 bits; `len` 17 bits, so a full 65536-byte image is valid; `pos` 16 bits.

## Test plan

- **Load and play `0x80`:** load 1 byte, raise `motor`.
  - Clock pulse at cycles 3..5252.
  - Data pulse at 42003..47252.
  - Bits 1–7 give clock pulses only.
  - `tape_end` rises at cycle 3+8×84000; `tape_pos` stays 0.
- **Two-byte gapless play:** load `0xFF,0x00` at `overclock`=3.
  - The byte 1 clock pulse starts exactly 8×7000 cycles after byte 0 starts.
  - Byte 0 cells show two pulses each; byte 1 cells show one.
- **Motor pause:** drop `motor` at phase 10000 of bit 2, hold 500 cycles, then raise it.
  - `cas_out` is 0 during the pause.
  - The next pulse edge is delayed by exactly 500 cycles.
- **Download during playback:** assert `ld_go` mid-cell.
  - `cas_out` drops next cycle; state is IDLE.
  - New `len` equals the highest address + 1.
  - Playback restarts at byte 0.
- **Rewind and reset:** assert `rewind` in END.
  - `tape_end` falls and playback restarts from byte 0 with the same `len`.
  - A `reset` pulse mid-pulse drives all outputs to 0 next cycle.
- **Overclock table:** for each `overclock` value 0–3, the measured T and PW match the table to the cycle.

Source files
------------

// File: rtl/cas_player.sv
// Cassette playback engine: captures a .CAS image into a private 64 KB RAM and
// replays it as a TRS-80 Level II 500-baud pulse stream gated by the motor relay.
module cas_player #(
    parameter int unsigned BIT_1X = 84000,
    parameter int unsigned PW_1X  = 5250
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ld_go,
    input  logic        ld_wr,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        motor,
    input  logic        rewind,
    input  logic [1:0]  overclock,
    output logic        cas_out,
    output logic        playing,
    output logic        tape_end,
    output logic [15:0] tape_pos
);

    localparam int unsigned PH_W    = 17;
    localparam int unsigned T_OC1   = BIT_1X * 2 / 3;
    localparam int unsigned T_OC2   = BIT_1X / 2;
    localparam int unsigned T_OC3   = BIT_1X / 12;
    localparam int unsigned PW_OC1  = PW_1X * 2 / 3;
    localparam int unsigned PW_OC2  = PW_1X / 2;
    localparam int unsigned PW_OC3  = PW_1X / 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CELL  = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t            state;
    logic              fetch_wait;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   t_cur;
    logic [PH_W-1:0]   pw_cur;
    logic [7:0]        shift;
    logic [7:0]        hold;
    logic [2:0]        bit_cnt;
    logic [15:0]       pos;

    logic [7:0]        mem [0:65535];
    logic [7:0]        rd_data;
    logic [15:0]       rd_addr_c;
    logic [16:0]       len;
    logic              ld_go_d;
    logic [16:0]       len_base_c;
    logic [16:0]       wr_end_c;

    logic [PH_W-1:0]   t_sel_c;
    logic [PH_W-1:0]   pw_sel_c;
    logic              last_c;
    logic [PH_W-1:0]   ph_nxt_c;
    logic [PH_W-1:0]   half_c;
    logic              pulse_c;
    logic              last_byte_c;

    assign playing  = (state == S_CELL) && motor;
    assign tape_pos = pos;

    // In CELL the read port always points at the next byte so the prefetch is free.
    assign rd_addr_c = (state == S_CELL) ? pos + 16'd1 : pos;

    always_ff @(posedge clk_sys) begin
        if (ld_go && ld_wr)
            mem[ld_addr] <= ld_data;
        rd_data <= mem[rd_addr_c];
    end

    // Image length tracks the highest written address; survives reset by design.
    assign len_base_c = (ld_go && !ld_go_d) ? 17'd0 : len;
    assign wr_end_c   = {1'b0, ld_addr} + 17'd1;

    always_ff @(posedge clk_sys) begin
        ld_go_d <= ld_go;
        if (ld_go && ld_wr)
            len <= (len_base_c >= wr_end_c) ? len_base_c : wr_end_c;
        else
            len <= len_base_c;
    end

    always_comb begin
        t_sel_c  = PH_W'(BIT_1X);
        pw_sel_c = PH_W'(PW_1X);
        case (overclock)
            2'd1: begin t_sel_c = PH_W'(T_OC1); pw_sel_c = PH_W'(PW_OC1); end
            2'd2: begin t_sel_c = PH_W'(T_OC2); pw_sel_c = PH_W'(PW_OC2); end
            2'd3: begin t_sel_c = PH_W'(T_OC3); pw_sel_c = PH_W'(PW_OC3); end
            default: ;
        endcase
    end

    // Level for the next cycle; phase 0 of every cell is always inside the clock pulse.
    always_comb begin
        last_c      = (phase == t_cur - PH_W'(1));
        ph_nxt_c    = last_c ? '0 : phase + PH_W'(1);
        half_c      = t_cur >> 1;
        pulse_c     = (ph_nxt_c < pw_cur) ||
                      (shift[7] && (ph_nxt_c >= half_c) && (ph_nxt_c < half_c + pw_cur));
        last_byte_c = (({1'b0, pos} + 17'd1) == len);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_wait <= 1'b0;
            phase      <= '0;
            t_cur      <= PH_W'(BIT_1X);
            pw_cur     <= PH_W'(PW_1X);
            shift      <= '0;
            hold       <= '0;
            bit_cnt    <= '0;
            pos        <= '0;
            cas_out    <= 1'b0;
            tape_end   <= 1'b0;
        end else if (ld_go || rewind) begin
            state      <= S_IDLE;
            fetch_wait <= 1'b0;
            pos        <= '0;
            cas_out    <= 1'b0;
            tape_end   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cas_out <= 1'b0;
                    pos     <= '0;
                    if (motor && (len != 17'd0)) begin
                        state      <= S_FETCH;
                        fetch_wait <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        shift      <= rd_data;
                        bit_cnt    <= '0;
                        phase      <= '0;
                        t_cur      <= t_sel_c;
                        pw_cur     <= pw_sel_c;
                        cas_out    <= 1'b1;
                        state      <= S_CELL;
                    end
                end
                S_CELL: begin
                    if (!motor) begin
                        cas_out <= 1'b0;
                    end else begin
                        phase   <= ph_nxt_c;
                        cas_out <= pulse_c;
                        if ((bit_cnt == 3'd7) && (phase != '0))
                            hold <= rd_data;
                        if (last_c) begin
                            t_cur  <= t_sel_c;
                            pw_cur <= pw_sel_c;
                            if (bit_cnt == 3'd7) begin
                                if (last_byte_c) begin
                                    state    <= S_END;
                                    cas_out  <= 1'b0;
                                    tape_end <= 1'b1;
                                end else begin
                                    pos     <= pos + 16'd1;
                                    shift   <= hold;
                                    bit_cnt <= '0;
                                end
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                S_END: begin
                    cas_out  <= 1'b0;
                    tape_end <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player using scaled timing (T=1200, PW=75 at 1x).
module tb_cas_player;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ld_go;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        motor;
    logic        rewind;
    logic [1:0]  overclock;
    logic        cas_out;
    logic        playing;
    logic        tape_end;
    logic [15:0] tape_pos;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int c0, t, r1, f1, r2;

    cas_player #(.BIT_1X(1200), .PW_1X(75)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ld_go     (ld_go),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .motor     (motor),
        .rewind    (rewind),
        .overclock (overclock),
        .cas_out   (cas_out),
        .playing   (playing),
        .tape_end  (tape_end),
        .tape_pos  (tape_pos)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns cycle of the next transition of cas_out to lvl, or -1 on timeout.
    task automatic wait_edge(input logic lvl, input int budget, output int tc);
        logic prev;
        prev = cas_out;
        tc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (cas_out === lvl && prev !== lvl) begin
                tc = cyc;
                return;
            end
            prev = cas_out;
        end
    endtask

    task automatic wait_end(input int budget, output int tc);
        tc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (tape_end === 1'b1) begin
                tc = cyc;
                return;
            end
        end
    endtask

    task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_wr   = 1'b1;
        @(negedge clk_sys);
        ld_wr   = 1'b0;
    endtask

    int t_exp [4]  = '{1200, 800, 600, 100};
    int pw_exp [4] = '{75, 50, 37, 6};
    int found;

    initial begin
        reset = 1'b1; ld_go = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        motor = 1'b0; rewind = 1'b0; overclock = 2'd0;
        repeat (3) @(negedge clk_sys);
        check("rst_cas_out", int'(cas_out), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_tape_end", int'(tape_end), 0);
        check("rst_tape_pos", int'(tape_pos), 0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Single byte 0x80 at 1x
        ld_go = 1'b1;
        @(negedge clk_sys);
        write_byte(16'd0, 8'h80);
        ld_go = 1'b0;
        @(negedge clk_sys);
        motor = 1'b1; c0 = cyc;
        wait_edge(1'b1, 100, t);  check("p1_clk_rise", t - c0, 3);
        check("p1_playing", int'(playing), 1);
        wait_edge(1'b0, 200, t);  check("p1_clk_fall", t - c0, 78);
        wait_edge(1'b1, 1000, t); check("p1_data_rise", t - c0, 603);
        wait_edge(1'b0, 200, t);  check("p1_data_fall", t - c0, 678);
        wait_edge(1'b1, 1000, t); check("p1_bit1_rise", t - c0, 1203);
        wait_end(10000, t);       check("p1_tape_end", t - c0, 9603);
        check("p1_tape_pos", int'(tape_pos), 0);
        check("p1_end_cas", int'(cas_out), 0);

        // Two bytes 0xFF,0x00 at 12x, gapless
        motor = 1'b0; ld_go = 1'b1;
        @(negedge clk_sys);
        write_byte(16'd0, 8'hFF);
        write_byte(16'd1, 8'h00);
        ld_go = 1'b0; overclock = 2'd3;
        @(negedge clk_sys);
        motor = 1'b1; c0 = cyc;
        for (int i = 0; i < 24; i++) begin
            wait_edge(1'b1, 200, t);
            if (i < 16) check($sformatf("p2_rise%0d", i), t - c0, 3 + 100 * (i / 2) + 50 * (i % 2));
            else        check($sformatf("p2_rise%0d", i), t - c0, 3 + 100 * (i - 8));
        end
        wait_end(500, t);         check("p2_tape_end", t - c0, 1603);
        check("p2_tape_pos", int'(tape_pos), 1);

        // Motor pause inside the bit-2 data pulse of 0x20 at 1x
        motor = 1'b0; ld_go = 1'b1;
        @(negedge clk_sys);
        write_byte(16'd0, 8'h20);
        ld_go = 1'b0; overclock = 2'd0;
        @(negedge clk_sys);
        motor = 1'b1; c0 = cyc;
        while (cyc < c0 + 3013) @(negedge clk_sys);
        check("p3_pre_pause", int'(cas_out), 1);
        motor = 1'b0;
        @(negedge clk_sys);
        check("p3_pause_cas", int'(cas_out), 0);
        check("p3_pause_playing", int'(playing), 0);
        while (cyc < c0 + 3513) @(negedge clk_sys);
        check("p3_pause_end_cas", int'(cas_out), 0);
        motor = 1'b1;
        @(negedge clk_sys);
        check("p3_resume_cas", int'(cas_out), 1);
        wait_edge(1'b0, 200, t);  check("p3_data_fall", t - c0, 3578);
        wait_edge(1'b1, 1000, t); check("p3_bit3_rise", t - c0, 4103);

        // New download mid-pulse; motor stays high
        ld_go = 1'b1;
        @(negedge clk_sys);
        check("p4_cas_drop", int'(cas_out), 0);
        check("p4_playing", int'(playing), 0);
        check("p4_tape_end", int'(tape_end), 0);
        check("p4_tape_pos", int'(tape_pos), 0);
        write_byte(16'd2, 8'h01);
        write_byte(16'd0, 8'h40);
        overclock = 2'd3; ld_go = 1'b0; c0 = cyc;
        wait_edge(1'b1, 100, t);  check("p4_rise0", t - c0, 3);
        wait_edge(1'b1, 200, t);  check("p4_rise1", t - c0, 103);
        wait_edge(1'b1, 200, t);  check("p4_rise2", t - c0, 153);
        wait_end(3000, t);        check("p4_tape_end_t", t - c0, 2403);
        check("p4_end_pos", int'(tape_pos), 2);

        // Rewind from END
        rewind = 1'b1; c0 = cyc;
        @(negedge clk_sys);
        rewind = 1'b0;
        check("p5_tape_end_clr", int'(tape_end), 0);
        check("p5_tape_pos", int'(tape_pos), 0);
        wait_edge(1'b1, 100, t);  check("p5_rise", t - c0, 4);
        wait_end(3000, t);        check("p5_tape_end_t", t - c0, 2404);
        check("p5_end_pos", int'(tape_pos), 2);

        // Reset during a byte-1 pulse
        rewind = 1'b1;
        @(negedge clk_sys);
        rewind = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk_sys);
            if (tape_pos == 16'd1 && cas_out === 1'b1) found = 1;
        end
        check("p5_found_pulse", found, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("p5_rst_cas", int'(cas_out), 0);
        check("p5_rst_playing", int'(playing), 0);
        check("p5_rst_tape_end", int'(tape_end), 0);
        check("p5_rst_tape_pos", int'(tape_pos), 0);
        reset = 1'b0; motor = 1'b0;
        @(negedge clk_sys);

        // Timing table; overclock changes mid-cell must not affect the current cell
        for (int oc = 0; oc < 4; oc++) begin
            overclock = 2'(oc);
            motor = 1'b1; rewind = 1'b1;
            @(negedge clk_sys);
            rewind = 1'b0;
            wait_edge(1'b1, 100, r1);
            overclock = 2'(oc + 1);
            wait_edge(1'b0, 200, f1);
            wait_edge(1'b1, 2000, r2);
            check($sformatf("p6_pw_oc%0d", oc), f1 - r1, pw_exp[oc]);
            check($sformatf("p6_t_oc%0d", oc), r2 - r1, t_exp[oc]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
